// File: rtl/hps_keys_pkg.sv
// Shared FSM state encodings and defaults for the HPS key debouncer.
`timescale 1ns/1ps
package hps_keys_pkg;

    localparam logic [1:0] RELEASED    = 2'd0;
    localparam logic [1:0] CHK_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] CHK_RELEASE = 2'd3;

    // 20 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM/counter and optional edge pulses.
// Edge pulses are built only when KEY_DEBOUNCE_EDGE_EN is defined.
`timescale 1ns/1ps
module key_debounce_ch
    import hps_keys_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic             IDLE_PIN = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {2{IDLE_PIN}};
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // Normalise so that s = 1 always means pressed
    assign s = sync_q[1] ^ IDLE_PIN;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = CHK_PRESS;
                    cnt_d   = '0;
                end
            end
            CHK_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = CHK_RELEASE;
                    cnt_d   = '0;
                end
            end
            CHK_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_d = (state_d == PRESSED) || (state_d == CHK_RELEASE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign key_level = level_q;

`ifdef KEY_DEBOUNCE_EDGE_EN
    logic press_q, release_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
`else
    assign key_press   = 1'b0;
    assign key_release = 1'b0;
`endif

endmodule

// File: rtl/hps_keys_debounce.sv
// Top level: NUM_KEYS independent debounce channels feeding the HPS key PIO.
// Optional press/release pulses enabled by defining KEY_DEBOUNCE_EDGE_EN.
`timescale 1ns/1ps
module hps_keys_debounce
    import hps_keys_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    if (DEBOUNCE_CYCLES < 2) begin : g_err_cycles
        $error("hps_keys_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_err_cnt_w
        $error("hps_keys_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_hps_keys_debounce.sv
// Scoreboard bench for hps_keys_debounce: a history-based debounce model predicts every cycle.
`timescale 1ns/1ps
module tb_hps_keys_debounce;

    localparam int NK = 2;
    localparam int D  = 8;
    localparam int CW = 4;
`ifdef KEY_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } exp_t;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key_raw = 2'b11;
    logic [NK-1:0] key_level, key_press, key_release;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hps_keys_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a key's level flips once the synchronised value has disagreed with it
    // for D+1 consecutive edges since the last flip. Sync delay is a 2-deep sample queue.
    logic [NK-1:0] dly[$];
    logic          hist[NK][$];
    logic [NK-1:0] lvl_m;

    task automatic model_reset();
        sb.delete();
        dly.delete();
        dly.push_back('0);
        dly.push_back('0);
        for (int k = 0; k < NK; k++) hist[k].delete();
        lvl_m = '0;
    endtask

    task automatic model_step();
        logic [NK-1:0] p, s;
        exp_t          e;
        bit            agree;
        e = '0;
        p = ~key_raw;
        s = dly.pop_front();
        dly.push_back(p);
        for (int k = 0; k < NK; k++) begin
            hist[k].push_back(s[k]);
            if (hist[k].size() > D + 1) void'(hist[k].pop_front());
            if (hist[k].size() == D + 1) begin
                agree = 1'b1;
                foreach (hist[k][j]) if (hist[k][j] == lvl_m[k]) agree = 1'b0;
                if (agree) begin
                    lvl_m[k] = ~lvl_m[k];
                    hist[k].delete();
                    e.prs[k] = EDGE_EN & lvl_m[k];
                    e.rel[k] = EDGE_EN & ~lvl_m[k];
                end
            end
        end
        e.lvl = lvl_m;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Monitor: compare DUT outputs against the scoreboard on every falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_hold", {26'd0, key_level, key_press, key_release}, 32'd0);
            end else if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("outputs", {26'd0, key_level, key_press, key_release}, {26'd0, e});
            end
        end
    end

    task automatic drive(input logic [NK-1:0] v);
        @(posedge clk);
        #2 key_raw = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Edges from the first sampling edge until key_level[b] == val; -1 if the bound expires
    task automatic measure(input int b, input logic val, output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (key_level[b] === val) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("reset_immediate", {26'd0, key_level, key_press, key_release}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int e;
        int n;
        logic [NK-1:0] v;

        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        idle(15);

        // Single key press and release latency
        drive(2'b10);
        measure(0, 1'b1, e);
        check("latency_press", e, 11);
        check("other_key_idle", {31'd0, key_level[1]}, 32'd0);
        idle(5);
        drive(2'b11);
        measure(0, 1'b0, e);
        check("latency_release", e, 11);
        idle(5);

        // Glitch of exactly D sampled edges is rejected; D+1 is accepted
        drive(2'b10);
        idle(7);
        drive(2'b11);
        idle(15);
        #1 check("glitch_level", {30'd0, key_level}, 32'd0);
        drive(2'b10);
        idle(8);
        drive(2'b11);
        idle(25);

        // Both keys together
        drive(2'b00);
        measure(0, 1'b1, e);
        check("both_rise", {30'd0, key_level}, 32'd3);
        idle(20);
        drive(2'b11);
        measure(0, 1'b0, e);
        check("both_fall", {30'd0, key_level}, 32'd0);
        idle(5);

        // Reset during CHK_RELEASE, then a full re-debounce
        drive(2'b10);
        idle(20);
        drive(2'b11);
        idle(3);
        pulse_reset();
        drive(2'b10);
        measure(0, 1'b1, e);
        check("latency_after_reset", e, 11);
        drive(2'b11);
        idle(15);

        // Randomised holds biased toward the debounce boundary
        for (int it = 0; it < 250; it++) begin
            v = NK'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, D - 2);
                1:       n = $urandom_range(D - 1, D);
                2:       n = D + 1;
                default: n = $urandom_range(12, 25);
            endcase
            drive(v);
            idle(n - 1);
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
